// File: rtl/fp_alu_arbiter.sv
// Round-robin arbiter sharing one FP ALU among NUM_REQ requesters.
// One operation in flight: capture winner, pulse start, wait (with timeout), respond.
module fp_alu_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*32-1:0] req_op_a,
  input  logic [NUM_REQ*32-1:0] req_op_b,
  input  logic [NUM_REQ*2-1:0]  req_op_code,
  input  logic [NUM_REQ-1:0]    req_mode_fp,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [31:0]           rsp_result,
  output logic [4:0]            rsp_flags,
  output logic                  rsp_timeout,
  output logic                  busy,
  output logic [31:0]           alu_op_a,
  output logic [31:0]           alu_op_b,
  output logic [1:0]            alu_op_code,
  output logic                  alu_mode_fp,
  output logic                  alu_start,
  input  logic [31:0]           alu_result,
  input  logic [4:0]            alu_flags,
  input  logic                  alu_valid_out
);

  localparam int unsigned GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e              state;
  logic [GW-1:0]       last_grant;
  logic [GW-1:0]       grant;
  logic [TW-1:0]       timer;

  logic [GW-1:0]       winner;
  logic [GW-1:0]       cand;
  logic                found;
  logic [NUM_REQ-1:0]  grant_oh;
  logic [31:0]         sel_a;
  logic [31:0]         sel_b;
  logic [1:0]          sel_code;
  logic                sel_mode;

  // Search starts just after the last served requester, so it ends up lowest priority.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = GW'((32'(last_grant) + k) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == StIdle && found) begin
      req_ready[winner] = 1'b1;
    end
  end

  always_comb begin
    sel_a    = req_op_a[32*winner +: 32];
    sel_b    = req_op_b[32*winner +: 32];
    sel_code = req_op_code[2*winner +: 2];
    sel_mode = req_mode_fp[winner];
  end

  always_comb begin
    grant_oh        = '0;
    grant_oh[grant] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= StIdle;
      last_grant  <= GW'(NUM_REQ - 1);
      grant       <= '0;
      timer       <= '0;
      alu_op_a    <= '0;
      alu_op_b    <= '0;
      alu_op_code <= '0;
      alu_mode_fp <= 1'b0;
      alu_start   <= 1'b0;
      rsp_valid   <= '0;
      rsp_result  <= '0;
      rsp_flags   <= '0;
      rsp_timeout <= 1'b0;
      busy        <= 1'b0;
    end else begin
      alu_start <= 1'b0;
      case (state)
        StIdle: begin
          if (found) begin
            grant       <= winner;
            alu_op_a    <= sel_a;
            alu_op_b    <= sel_b;
            alu_op_code <= sel_code;
            alu_mode_fp <= sel_mode;
            alu_start   <= 1'b1;
            busy        <= 1'b1;
            state       <= StIssue;
          end
        end
        StIssue: begin
          timer <= '0;
          state <= StWait;
        end
        StWait: begin
          // A result arriving on the last timeout cycle still counts as a result.
          if (alu_valid_out) begin
            rsp_result  <= alu_result;
            rsp_flags   <= alu_flags;
            rsp_timeout <= 1'b0;
            rsp_valid   <= grant_oh;
            state       <= StResp;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            rsp_result  <= '0;
            rsp_flags   <= '0;
            rsp_timeout <= 1'b1;
            rsp_valid   <= grant_oh;
            state       <= StResp;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        StResp: begin
          rsp_valid   <= '0;
          rsp_result  <= '0;
          rsp_flags   <= '0;
          rsp_timeout <= 1'b0;
          last_grant  <= grant;
          busy        <= 1'b0;
          state       <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

  a_ready_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready));
  a_rsp_onehot:   assert property (@(posedge clk) disable iff (rst) $onehot0(rsp_valid));
  a_start_pulse:  assert property (@(posedge clk) disable iff (rst) alu_start |=> !alu_start);

endmodule

// File: tb/tb_fp_alu_arbiter.sv
// Scoreboard bench for fp_alu_arbiter: requester driver, fixed-latency ALU stub,
// round-robin reference model and a response monitor.
module tb_fp_alu_arbiter;
  localparam int N   = 4;
  localparam int TO  = 8;
  localparam int LAT = 2;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  code;
    logic        mode;
  } op_t;

  typedef struct {
    int          idx;
    logic [31:0] res;
    logic [4:0]  fl;
    logic        to;
    int          cyc;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*32-1:0] req_op_a = '0;
  logic [N*32-1:0] req_op_b = '0;
  logic [N*2-1:0]  req_op_code = '0;
  logic [N-1:0]    req_mode_fp = '0;
  logic [N-1:0]    rsp_valid;
  logic [31:0]     rsp_result;
  logic [4:0]      rsp_flags;
  logic            rsp_timeout;
  logic            busy;
  logic [31:0]     alu_op_a;
  logic [31:0]     alu_op_b;
  logic [1:0]      alu_op_code;
  logic            alu_mode_fp;
  logic            alu_start;
  logic [31:0]     alu_result = '0;
  logic [4:0]      alu_flags = '0;
  logic            alu_valid_out = 1'b0;

  fp_alu_arbiter #(
    .NUM_REQ(N),
    .TIMEOUT(TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op_a     (req_op_a),
    .req_op_b     (req_op_b),
    .req_op_code  (req_op_code),
    .req_mode_fp  (req_mode_fp),
    .rsp_valid    (rsp_valid),
    .rsp_result   (rsp_result),
    .rsp_flags    (rsp_flags),
    .rsp_timeout  (rsp_timeout),
    .busy         (busy),
    .alu_op_a     (alu_op_a),
    .alu_op_b     (alu_op_b),
    .alu_op_code  (alu_op_code),
    .alu_mode_fp  (alu_mode_fp),
    .alu_start    (alu_start),
    .alu_result   (alu_result),
    .alu_flags    (alu_flags),
    .alu_valid_out(alu_valid_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   checks = 0;
  int   errors = 0;
  op_t  pend[N][$];
  exp_t sb[$];
  int   m_last = N - 1;
  bit   m_busy = 1'b0;
  int   idle_cyc = 0;
  int   acc_cyc = 0;
  bit   alu_dead = 1'b0;
  int   alu_lat = LAT;
  bit   poke = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Plain real-number FP model of the ALU (normal numbers only).
  function automatic real pow2(input int n);
    real r;
    r = 1.0;
    if (n > 0) for (int i = 0; i < n; i++) r = r * 2.0;
    else for (int i = 0; i < -n; i++) r = r / 2.0;
    return r;
  endfunction

  function automatic real fp_decode(input logic [31:0] v, input bit single);
    int  e;
    int  m;
    int  mb;
    int  bias;
    bit  s;
    real r;
    if (single) begin
      s = v[31]; e = int'(v[30:23]); m = int'(v[22:0]); mb = 23; bias = 127;
    end else begin
      s = v[15]; e = int'(v[14:10]); m = int'(v[9:0]); mb = 10; bias = 15;
    end
    if (e == 0) return 0.0;
    r = (1.0 + real'(m) / pow2(mb)) * pow2(e - bias);
    return s ? -r : r;
  endfunction

  function automatic logic [31:0] fp_encode(input real r, input bit single);
    int  e;
    int  m;
    int  mb;
    int  bias;
    int  emax;
    bit  s;
    real a;
    mb   = single ? 23 : 10;
    bias = single ? 127 : 15;
    emax = single ? 254 : 30;
    if (r == 0.0) return 32'h0;
    s = (r < 0.0);
    a = s ? -r : r;
    e = 0;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0) begin a = a * 2.0; e--; end
    m = $rtoi((a - 1.0) * pow2(mb) + 0.5);
    if (m == (1 << mb)) begin m = 0; e++; end
    e = e + bias;
    if (e < 1) return 32'h0;
    if (e > emax) begin e = emax + 1; m = 0; end
    if (single) return {s, 8'(e), 23'(m)};
    return {16'h0, s, 5'(e), 10'(m)};
  endfunction

  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [1:0] code, input logic mode);
    real x;
    real y;
    real r;
    x = fp_decode(a, mode);
    y = fp_decode(b, mode);
    case (code)
      2'd0:    r = x + y;
      2'd1:    r = x - y;
      2'd2:    r = x * y;
      default: r = x / y;
    endcase
    return fp_encode(r, mode);
  endfunction

  function automatic logic [4:0] flag_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [1:0] code, input logic mode);
    return {a[1:0] ^ b[1:0], mode, code};
  endfunction

  function automatic logic [31:0] rnd_fp(input logic mode);
    logic [31:0] v;
    v = $urandom;
    if (mode) v[30:23] = 8'($urandom_range(150, 100));
    else v[14:10] = 5'($urandom_range(20, 10));
    return v;
  endfunction

  task automatic push(input int i, input logic [31:0] a, input logic [31:0] b,
                      input logic [1:0] code, input logic mode);
    op_t o;
    o.a = a; o.b = b; o.code = code; o.mode = mode;
    pend[i].push_back(o);
  endtask

  function automatic bit any_pend();
    for (int i = 0; i < N; i++) if (pend[i].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((any_pend() || sb.size() != 0 || m_busy) && n < 400) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (n >= 400) begin
      errors++;
      $display("FAIL %s: not drained after %0d cycles, required all responses", name, n);
    end
    @(posedge clk);
  endtask

  // Requester driver plus round-robin reference: decides who must be accepted.
  initial begin : driver
    int          w;
    int          c;
    logic [N-1:0] er;
    op_t         o;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        w = -1;
        if (!m_busy && cyc >= idle_cyc) begin
          for (int k = 1; k <= N; k++) begin
            c = (m_last + k) % N;
            if (w < 0 && req_valid[c]) w = c;
          end
        end
        er = '0;
        if (w >= 0) er[w] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(er));
        if (w >= 0 && pend[w].size() != 0) begin
          o     = pend[w].pop_front();
          e.idx = w;
          e.to  = alu_dead || (alu_lat > TO);
          e.res = e.to ? 32'h0 : alu_fn(o.a, o.b, o.code, o.mode);
          e.fl  = e.to ? 5'h0 : flag_fn(o.a, o.b, o.code, o.mode);
          e.cyc = cyc + 2 + (e.to ? TO : alu_lat);
          sb.push_back(e);
          m_busy  = 1'b1;
          acc_cyc = cyc;
        end
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (pend[i].size() != 0) begin
          req_valid[i]          = 1'b1;
          req_op_a[32*i +: 32]  = pend[i][0].a;
          req_op_b[32*i +: 32]  = pend[i][0].b;
          req_op_code[2*i +: 2] = pend[i][0].code;
          req_mode_fp[i]        = pend[i][0].mode;
        end else begin
          req_valid[i]          = 1'b0;
          req_op_a[32*i +: 32]  = $urandom;
          req_op_b[32*i +: 32]  = $urandom;
          req_op_code[2*i +: 2] = 2'($urandom);
          req_mode_fp[i]        = 1'($urandom);
        end
      end
    end
  end

  // ALU stub: answers alu_lat cycles after start unless alu_dead.
  initial begin : alu_model
    bit          abusy;
    int          cnt;
    logic [31:0] ca;
    logic [31:0] cb;
    logic [1:0]  cc;
    logic        cm;
    abusy = 1'b0;
    cnt   = 0;
    forever begin
      @(posedge clk);
      #1;
      alu_valid_out = 1'b0;
      if (poke) begin
        alu_valid_out = 1'b1;
        alu_result    = 32'hDEAD_BEEF;
        alu_flags     = 5'h1F;
        poke          = 1'b0;
      end
      if (abusy) begin
        cnt--;
        if (cnt == 0) begin
          abusy = 1'b0;
          if (!alu_dead) begin
            alu_valid_out = 1'b1;
            alu_result    = alu_fn(ca, cb, cc, cm);
            alu_flags     = flag_fn(ca, cb, cc, cm);
          end
        end
      end
      if (alu_start && !rst) begin
        chk("start_overlap", 64'(abusy), 64'(0));
        chk("start_cycle", 64'(cyc), 64'(acc_cyc + 1));
        ca = alu_op_a; cb = alu_op_b; cc = alu_op_code; cm = alu_mode_fp;
        abusy = 1'b1;
        cnt   = alu_lat;
      end
    end
  end

  // Response monitor: pops the scoreboard whenever a response pulse appears.
  initial begin : monitor
    exp_t         e;
    logic [N-1:0] oh;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (rsp_valid != '0) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_unexpected: got rsp_valid %b, expected none (cycle %0d)",
                     rsp_valid, cyc);
          end else begin
            e = sb.pop_front();
            oh = '0;
            oh[e.idx] = 1'b1;
            chk("rsp_valid", 64'(rsp_valid), 64'(oh));
            chk("rsp_result", 64'(rsp_result), 64'(e.res));
            chk("rsp_flags_timeout", 64'({rsp_timeout, rsp_flags}), 64'({e.to, e.fl}));
            chk("rsp_cycle", 64'(cyc), 64'(e.cyc));
            idle_cyc = cyc + 1;
            m_last   = e.idx;
            m_busy   = 1'b0;
          end
        end else begin
          chk("rsp_quiet", 64'({rsp_result, rsp_flags, rsp_timeout}), 64'(0));
        end
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ctl"}, 64'({busy, alu_start, rsp_valid, rsp_timeout, rsp_flags, alu_op_code,
                            alu_mode_fp}), 64'(0));
    chk({tag, "_ops"}, {alu_op_a, alu_op_b}, 64'(0));
    chk({tag, "_result"}, 64'(rsp_result), 64'(0));
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: bench did not complete, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int n;
    logic m;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    #1;
    rst = 1'b0;

    // Single half-precision add from requester 0.
    push(0, 32'h0000_3C00, 32'h0000_4000, 2'd0, 1'b0);
    drain("single_add");

    // Two requesters in the same cycle: sub then mul.
    push(1, 32'h0000_4000, 32'h0000_3800, 2'd1, 1'b0);
    push(2, 32'h0000_4000, 32'h0000_4200, 2'd2, 1'b0);
    drain("pair");

    // All four saturating for two rounds of divides.
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) push(i, 32'h0000_4800, 32'h0000_4000, 2'd3, 1'b0);
    drain("all_four");

    // ALU never answers, then a normal op.
    alu_dead = 1'b1;
    push(2, 32'h0000_3C00, 32'h0000_3C00, 2'd0, 1'b0);
    drain("timeout");
    alu_dead = 1'b0;
    push(1, 32'h3F80_0000, 32'h4000_0000, 2'd2, 1'b1);
    drain("after_timeout");

    // Answer on the last timeout cycle wins; one cycle later is a timeout.
    alu_lat = TO;
    push(3, 32'h0000_4400, 32'h0000_3C00, 2'd1, 1'b0);
    drain("late_valid_wins");
    alu_lat = TO + 1;
    push(0, 32'h0000_4400, 32'h0000_3C00, 2'd0, 1'b0);
    drain("too_late");
    alu_lat = LAT;

    // Reset in the middle of WAIT.
    alu_lat = 6;
    push(0, 32'h0000_4000, 32'h0000_4000, 2'd0, 1'b0);
    n = 0;
    while (!m_busy && n < 50) begin @(posedge clk); #1; n++; end
    chk("reset_test_accept", 64'(m_busy), 64'(1));
    while (cyc < acc_cyc + 3) begin @(posedge clk); #1; end
    #1;
    rst = 1'b1;
    #1;
    chk_reset_outputs("mid_reset");
    sb.delete();
    m_busy   = 1'b0;
    m_last   = N - 1;
    idle_cyc = 0;
    @(posedge clk);
    #2;
    rst = 1'b0;
    repeat (8) begin
      @(negedge clk);
      chk("stale_busy", 64'({busy, rsp_valid}), 64'(0));
    end
    alu_lat = LAT;
    push(3, 32'h0000_3C00, 32'h0000_4000, 2'd0, 1'b0);
    drain("after_reset");

    // Stray ALU valid while idle.
    @(negedge clk);
    poke = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("idle_poke", 64'({busy, rsp_valid}), 64'(0));
    end

    // Random traffic.
    for (int k = 0; k < 40; k++) begin
      n = $urandom_range(N - 1, 0);
      m = 1'($urandom);
      push(n, rnd_fp(m), rnd_fp(m), 2'($urandom), m);
      repeat ($urandom_range(6, 0)) @(posedge clk);
    end
    drain("random");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
